// File: rtl/mem_req_ctrl_pkg.sv
// Shared types and widths for the memory request controller.
// The optional watchdog is enabled by defining MEM_TIMEOUT_EN.
package mem_req_ctrl_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } mem_ctrl_state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_req_ctrl_chk.sv
// Assertion checker for mem_req_ctrl: parameter legality and credit return overflow.
module mem_req_ctrl_chk #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CREDITS         = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 255,
  parameter int unsigned CW              = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          rsp_consumed,
  input logic [CW-1:0] credits
);

  // A returned credit while already full means downstream consumed something never sent.
  credit_overflow_a : assert property (@(posedge clk) disable iff (rst)
    rsp_consumed |-> (credits != CW'(CREDITS)));

  param_range_a : assert property (@(posedge clk) disable iff (rst)
    (MAX_OUTSTANDING >= 32'd1) && (MAX_OUTSTANDING <= 32'd7) && (TIMEOUT_CYCLES >= 32'd1));

endmodule

// File: rtl/mem_req_ctrl_sat_updown_ctr.sv
// Saturating up/down counter with synchronous load; simultaneous inc and dec hold the value.
module sat_updown_ctr #(
  parameter int unsigned MAX     = 2,
  parameter int unsigned WIDTH   = $clog2(MAX + 1),
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_r;

  // Count register: load wins, then saturating step in either direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= WIDTH'(RST_VAL);
    end else if (load) begin
      count_r <= load_val;
    end else if (inc && !dec && (count_r != WIDTH'(MAX))) begin
      count_r <= count_r + WIDTH'(1'b1);
    end else if (dec && !inc && (count_r != {WIDTH{1'b0}})) begin
      count_r <= count_r - WIDTH'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/mem_req_ctrl.sv
// Memory request controller: single hold register, outstanding-read and credit tracking,
// flush/drain, registered response pair. Optional watchdog under MEM_TIMEOUT_EN.
module mem_req_ctrl
  import mem_req_ctrl_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CREDITS         = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  mem_req_vld,
  input  logic                  mem_req_rdy,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_rsp_vld,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  m_rsp_vld,
  output logic [DATA_WIDTH-1:0] m_rsp_data,
  input  logic                  rsp_consumed,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  busy,
  output logic                  spurious_err,
  output logic                  timeout_err
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CW = $clog2(CREDITS + 1);

  mem_ctrl_state_t       state_r, state_s;
  mem_req_t              hold_r;
  logic                  flush_seen_r;
  logic                  m_rsp_vld_r, flush_done_r, spur_r;
  logic [DATA_WIDTH-1:0] m_rsp_data_r;
  logic [OW-1:0]         outst_s, outst_ld_s;
  logic [CW-1:0]         credits_s, credits_ld_s;
  logic                  req_rdy_s, req_fire_s, mem_fire_s, rd_fire_s, rsp_ok_s;
  logic                  drain_exit_s, tmo_hit_s;

  assign req_rdy_s  = (state_r == IDLE) && !flush &&
                      (req_we || ((outst_s < OW'(MAX_OUTSTANDING)) && (credits_s != {CW{1'b0}})));
  assign req_fire_s = req_vld && req_rdy_s;
  assign mem_fire_s = (state_r == ISSUE) && mem_req_rdy;
  assign rd_fire_s  = mem_fire_s && !hold_r.we;
  assign rsp_ok_s   = mem_rsp_vld && (outst_s != {OW{1'b0}});

  // A watchdog reset must not lose a read issued in the very same cycle.
  assign outst_ld_s   = rd_fire_s ? OW'(1'b1) : {OW{1'b0}};
  assign credits_ld_s = CW'(CREDITS) - (rd_fire_s ? CW'(1'b1) : {CW{1'b0}});

  sat_updown_ctr #(.MAX(MAX_OUTSTANDING), .WIDTH(OW), .RST_VAL(0)) u_outst_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmo_hit_s),
    .load_val (outst_ld_s),
    .inc      (rd_fire_s),
    .dec      (rsp_ok_s),
    .count    (outst_s)
  );

  sat_updown_ctr #(.MAX(CREDITS), .WIDTH(CW), .RST_VAL(CREDITS)) u_credit_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmo_hit_s),
    .load_val (credits_ld_s),
    .inc      (rsp_consumed),
    .dec      (rd_fire_s),
    .count    (credits_s)
  );

  // Next-state logic; DRAIN exits in the cycle the last outstanding read returns.
  always_comb begin
    state_s      = state_r;
    drain_exit_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (flush) begin
          state_s = DRAIN;
        end else if (req_fire_s) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (mem_fire_s) begin
          state_s = (flush_seen_r || flush) ? DRAIN : IDLE;
        end else begin
          state_s = ISSUE;
        end
      end
      DRAIN: begin
        if ((outst_s == {OW{1'b0}}) || ((outst_s == OW'(1'b1)) && rsp_ok_s) || tmo_hit_s) begin
          state_s      = IDLE;
          drain_exit_s = 1'b1;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, hold register and flush memory while a request is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      hold_r       <= '{we: 1'b0, addr: {ADDR_WIDTH{1'b0}}, wdata: {DATA_WIDTH{1'b0}}};
      flush_seen_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (req_fire_s) begin
        hold_r <= '{we: req_we, addr: req_addr, wdata: req_wdata};
      end else begin
        hold_r <= hold_r;
      end
      if (state_r != ISSUE) begin
        flush_seen_r <= 1'b0;
      end else if (flush) begin
        flush_seen_r <= 1'b1;
      end else begin
        flush_seen_r <= flush_seen_r;
      end
    end
  end

  // Registered response pair, drain-done pulse and sticky spurious flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rsp_vld_r  <= 1'b0;
      m_rsp_data_r <= {DATA_WIDTH{1'b0}};
      flush_done_r <= 1'b0;
      spur_r       <= 1'b0;
    end else begin
      m_rsp_vld_r  <= rsp_ok_s;
      m_rsp_data_r <= rsp_ok_s ? mem_rsp_data : m_rsp_data_r;
      flush_done_r <= drain_exit_s;
      spur_r       <= spur_r || (mem_rsp_vld && (outst_s == {OW{1'b0}}));
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] wdog_r;
  logic          tmo_r;
  logic          wdog_run_s;

  assign wdog_run_s = (outst_s != {OW{1'b0}}) && !mem_rsp_vld;
  assign tmo_hit_s  = wdog_run_s && (wdog_r == WW'(TIMEOUT_CYCLES - 32'd1));

  // Watchdog: counts silent cycles with reads in flight; any response restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_r <= {WW{1'b0}};
      tmo_r  <= 1'b0;
    end else begin
      if (!wdog_run_s || tmo_hit_s) begin
        wdog_r <= {WW{1'b0}};
      end else begin
        wdog_r <= wdog_r + WW'(1'b1);
      end
      tmo_r <= tmo_r || tmo_hit_s;
    end
  end

  assign timeout_err = tmo_r;
`else
  assign tmo_hit_s   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign req_rdy       = req_rdy_s;
  assign mem_req_vld   = (state_r == ISSUE);
  assign mem_req_we    = hold_r.we;
  assign mem_req_addr  = hold_r.addr;
  assign mem_req_wdata = hold_r.wdata;
  assign m_rsp_vld     = m_rsp_vld_r;
  assign m_rsp_data    = m_rsp_data_r;
  assign flush_done    = flush_done_r;
  assign busy          = (state_r == ISSUE) || (outst_s != {OW{1'b0}});
  assign spurious_err  = spur_r;

  mem_req_ctrl_chk #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CREDITS         (CREDITS),
    .TIMEOUT_CYCLES  (TIMEOUT_CYCLES),
    .CW              (CW)
  ) u_chk (
    .clk          (clk),
    .rst          (rst),
    .rsp_consumed (rsp_consumed),
    .credits      (credits_s)
  );

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed table-driven bench for mem_req_ctrl plus hand sequences for stall, flush, reset and timeout.
module tb_mem_req_ctrl;
  import mem_req_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_vld, req_rdy, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req_vld, mem_req_rdy, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_rsp_vld;
  logic [31:0] mem_rsp_data;
  logic        m_rsp_vld;
  logic [31:0] m_rsp_data;
  logic        rsp_consumed, flush, flush_done, busy, spurious_err, timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_req_ctrl #(.MAX_OUTSTANDING(2), .CREDITS(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_vld(mem_rsp_vld), .mem_rsp_data(mem_rsp_data),
    .m_rsp_vld(m_rsp_vld), .m_rsp_data(m_rsp_data),
    .rsp_consumed(rsp_consumed), .flush(flush), .flush_done(flush_done),
    .busy(busy), .spurious_err(spurious_err), .timeout_err(timeout_err)
  );

  typedef struct {
    logic        rv, we;
    logic [31:0] addr, wd;
    logic        mrdy, rspv;
    logic [31:0] rspd;
    logic        cons;
    logic        e_rdy, e_mvld;
    logic [31:0] e_maddr;
    logic        e_mrv;
    logic [31:0] e_mrd;
    logic        e_busy;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(input logic rv, input logic we, input logic [31:0] addr,
                              input logic [31:0] wd, input logic mrdy, input logic rspv,
                              input logic [31:0] rspd, input logic cons, input logic e_rdy,
                              input logic e_mvld, input logic [31:0] e_maddr, input logic e_mrv,
                              input logic [31:0] e_mrd, input logic e_busy);
    vec_t v;
    v.rv = rv; v.we = we; v.addr = addr; v.wd = wd; v.mrdy = mrdy; v.rspv = rspv;
    v.rspd = rspd; v.cons = cons; v.e_rdy = e_rdy; v.e_mvld = e_mvld; v.e_maddr = e_maddr;
    v.e_mrv = e_mrv; v.e_mrd = e_mrd; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_vld = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    mem_req_rdy = 1'b1; mem_rsp_vld = 1'b0; mem_rsp_data = 32'h0;
    rsp_consumed = 1'b0; flush = 1'b0;
  endtask

  // Accept a load, then let memory take it; returns #1 after the issue edge.
  task automatic issue_load(input logic [31:0] a);
    req_vld = 1'b1; req_we = 1'b0; req_addr = a; mem_req_rdy = 1'b1;
    @(negedge clk);
    chk("load_accept_rdy", {31'd0, req_rdy}, 32'd1);
    tick();
    req_vld = 1'b0;
    @(negedge clk);
    chk("load_issue_addr", mem_req_addr, a);
    tick();
  endtask

  initial begin
    tbl[0]  = mk(1'b1, 1'b0, 32'h10,  32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0);
    tbl[1]  = mk(1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h10,  1'b0, 32'h0,        1'b1);
    tbl[2]  = mk(1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h10,  1'b0, 32'h0,        1'b1);
    tbl[3]  = mk(1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h10,  1'b0, 32'h0,        1'b1);
    tbl[4]  = mk(1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h10,  1'b0, 32'h0,        1'b1);
    tbl[5]  = mk(1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h10,  1'b1, 32'hDEADBEEF, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h10,  1'b0, 32'hDEADBEEF, 1'b0);
    tbl[7]  = mk(1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h10,  1'b0, 32'hDEADBEEF, 1'b0);
    tbl[8]  = mk(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h10,  1'b0, 32'hDEADBEEF, 1'b0);
    tbl[9]  = mk(1'b1, 1'b0, 32'h104, 32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'hDEADBEEF, 1'b1);
    tbl[10] = mk(1'b1, 1'b0, 32'h104, 32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 32'hDEADBEEF, 1'b1);
    tbl[11] = mk(1'b1, 1'b0, 32'h108, 32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h104, 1'b0, 32'hDEADBEEF, 1'b1);
    tbl[12] = mk(1'b1, 1'b0, 32'h108, 32'h0, 1'b1, 1'b1, 32'hA1,       1'b0, 1'b0, 1'b0, 32'h104, 1'b0, 32'hDEADBEEF, 1'b1);
    tbl[13] = mk(1'b1, 1'b0, 32'h108, 32'h0, 1'b1, 1'b1, 32'hA2,       1'b0, 1'b0, 1'b0, 32'h104, 1'b1, 32'hA1,       1'b1);
    tbl[14] = mk(1'b1, 1'b0, 32'h108, 32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h104, 1'b1, 32'hA2,       1'b0);
    tbl[15] = mk(1'b1, 1'b0, 32'h108, 32'h0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h104, 1'b0, 32'hA2,       1'b0);
    tbl[16] = mk(1'b1, 1'b0, 32'h108, 32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h104, 1'b0, 32'hA2,       1'b0);
    tbl[17] = mk(1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h108, 1'b0, 32'hA2,       1'b1);
    tbl[18] = mk(1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 1'b1, 32'hA3,       1'b0, 1'b0, 1'b0, 32'h108, 1'b0, 32'hA2,       1'b1);
    tbl[19] = mk(1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h108, 1'b1, 32'hA3,       1'b0);
    tbl[20] = mk(1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h108, 1'b0, 32'hA3,       1'b0);
    tbl[21] = mk(1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h108, 1'b0, 32'hA3,       1'b0);

    // Reset state
    idle_inputs();
    rst = 1'b1;
    #12;
    chk("rst_mem_req_vld", {31'd0, mem_req_vld}, 32'd0);
    chk("rst_m_rsp_vld", {31'd0, m_rsp_vld}, 32'd0);
    chk("rst_m_rsp_data", m_rsp_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_spurious", {31'd0, spurious_err}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
    chk("rst_flush_done", {31'd0, flush_done}, 32'd0);
    chk("rst_credits", 32'(dut.credits_s), 32'd2);
    chk("rst_outstanding", 32'(dut.outst_s), 32'd0);
    tick();
    rst = 1'b0;
    #1;

    // Single load, then three back-to-back loads against two credits
    for (int i = 0; i < 22; i++) begin
      req_vld = tbl[i].rv; req_we = tbl[i].we; req_addr = tbl[i].addr; req_wdata = tbl[i].wd;
      mem_req_rdy = tbl[i].mrdy; mem_rsp_vld = tbl[i].rspv; mem_rsp_data = tbl[i].rspd;
      rsp_consumed = tbl[i].cons; flush = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_req_rdy", i), {31'd0, req_rdy}, {31'd0, tbl[i].e_rdy});
      chk($sformatf("v%0d_mem_req_vld", i), {31'd0, mem_req_vld}, {31'd0, tbl[i].e_mvld});
      chk($sformatf("v%0d_mem_req_addr", i), mem_req_addr, tbl[i].e_maddr);
      chk($sformatf("v%0d_m_rsp_vld", i), {31'd0, m_rsp_vld}, {31'd0, tbl[i].e_mrv});
      chk($sformatf("v%0d_m_rsp_data", i), m_rsp_data, tbl[i].e_mrd);
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].e_busy});
      chk($sformatf("v%0d_spurious", i), {31'd0, spurious_err}, 32'd0);
      tick();
    end
    idle_inputs();

    // Store with four stall cycles
    req_vld = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55AA_1234; mem_req_rdy = 1'b0;
    @(negedge clk);
    chk("st_req_rdy", {31'd0, req_rdy}, 32'd1);
    tick();
    req_vld = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("st_stall_vld", {31'd0, mem_req_vld}, 32'd1);
      chk("st_stall_we", {31'd0, mem_req_we}, 32'd1);
      chk("st_stall_addr", mem_req_addr, 32'h20);
      chk("st_stall_wdata", mem_req_wdata, 32'h55AA_1234);
      tick();
    end
    mem_req_rdy = 1'b1;
    @(negedge clk);
    chk("st_fire_vld", {31'd0, mem_req_vld}, 32'd1);
    tick();
    @(negedge clk);
    chk("st_done_vld", {31'd0, mem_req_vld}, 32'd0);
    chk("st_credits", 32'(dut.credits_s), 32'd2);
    chk("st_outstanding", 32'(dut.outst_s), 32'd0);
    chk("st_busy", {31'd0, busy}, 32'd0);
    tick();

    // Flush with two loads outstanding
    issue_load(32'h200);
    issue_load(32'h204);
    chk("fl_outstanding", 32'(dut.outst_s), 32'd2);
    flush = 1'b1; req_vld = 1'b1; req_we = 1'b1; req_addr = 32'h300;
    @(negedge clk);
    chk("fl_req_rdy", {31'd0, req_rdy}, 32'd0);
    tick();
    flush = 1'b0; req_vld = 1'b0; req_we = 1'b0;
    chk("fl_state_drain", 32'(dut.state_r), 32'(DRAIN));
    @(negedge clk);
    chk("fl_done_early0", {31'd0, flush_done}, 32'd0);
    tick();
    mem_rsp_vld = 1'b1; mem_rsp_data = 32'hB1;
    @(negedge clk);
    chk("fl_done_early1", {31'd0, flush_done}, 32'd0);
    tick();
    mem_rsp_data = 32'hB2;
    @(negedge clk);
    chk("fl_done_early2", {31'd0, flush_done}, 32'd0);
    chk("fl_state_still_drain", 32'(dut.state_r), 32'(DRAIN));
    tick();
    mem_rsp_vld = 1'b0;
    @(negedge clk);
    chk("fl_done_pulse", {31'd0, flush_done}, 32'd1);
    chk("fl_last_rsp_vld", {31'd0, m_rsp_vld}, 32'd1);
    chk("fl_last_rsp_data", m_rsp_data, 32'hB2);
    chk("fl_state_idle", 32'(dut.state_r), 32'(IDLE));
    tick();
    @(negedge clk);
    chk("fl_done_single", {31'd0, flush_done}, 32'd0);
    rsp_consumed = 1'b1;
    tick();
    tick();
    rsp_consumed = 1'b0;
    chk("fl_credits_back", 32'(dut.credits_s), 32'd2);

    // Spurious response, then reset in the middle of ISSUE
    mem_rsp_vld = 1'b1; mem_rsp_data = 32'h77;
    tick();
    mem_rsp_vld = 1'b0;
    @(negedge clk);
    chk("sp_no_rsp_vld", {31'd0, m_rsp_vld}, 32'd0);
    chk("sp_err_set", {31'd0, spurious_err}, 32'd1);
    tick();
    tick();
    chk("sp_err_sticky", {31'd0, spurious_err}, 32'd1);
    req_vld = 1'b1; req_we = 1'b0; req_addr = 32'h400; mem_req_rdy = 1'b0;
    tick();
    req_vld = 1'b0;
    chk("rs_in_issue", {31'd0, mem_req_vld}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_async_vld", {31'd0, mem_req_vld}, 32'd0);
    chk("rs_spur_clear", {31'd0, spurious_err}, 32'd0);
    chk("rs_credits", 32'(dut.credits_s), 32'd2);
    tick();
    rst = 1'b0;
    mem_req_rdy = 1'b1;
    mem_rsp_vld = 1'b1; mem_rsp_data = 32'h88;
    tick();
    mem_rsp_vld = 1'b0;
    @(negedge clk);
    chk("rs_late_no_vld", {31'd0, m_rsp_vld}, 32'd0);
    chk("rs_late_spur", {31'd0, spurious_err}, 32'd1);
    chk("rs_no_timeout", {31'd0, timeout_err}, 32'd0);
    tick();

`ifdef MEM_TIMEOUT_EN
    // Watchdog: load issued, memory stays silent
    issue_load(32'h500);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("to_err_k%0d", k), {31'd0, timeout_err}, (k == 8) ? 32'd1 : 32'd0);
    end
    chk("to_outstanding", 32'(dut.outst_s), 32'd0);
    chk("to_credits", 32'(dut.credits_s), 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Memory request controller directly upstream of the read-response skid buffer.
- Accepts load/store requests from the core-side LSU and issues them to memory over a valid/ready channel.
- Tracks outstanding reads and drives the registered m_rsp_vld/m_rsp_data pair that feeds the skid buffer.
- Uses credit-based throttling so the downstream holding registers (output reg + skid reg) never overflow.

Parameters:
- MAX_OUTSTANDING, 2, maximum reads in flight to memory (1..7).
- CREDITS, 2, downstream response slots: src_data reg plus skid_reg.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_vld  in  1  core request valid
- req_rdy  out  1  core request ready
- req_we  in  1  1=store, 0=load
- req_addr  in  ADDR_WIDTH  request address
- req_wdata  in  DATA_WIDTH  store data
- mem_req_vld  out  1  memory request valid
- mem_req_rdy  in  1  memory request ready
- mem_req_we  out  1  memory write enable
- mem_req_addr  out  ADDR_WIDTH  memory address
- mem_req_wdata  out  DATA_WIDTH  memory write data
- mem_rsp_vld  in  1  memory read response valid (no backpressure)
- mem_rsp_data  in  DATA_WIDTH  memory read data
- m_rsp_vld  out  1  response valid to skid buffer
- m_rsp_data  out  DATA_WIDTH  response data to skid buffer
- rsp_consumed  in  1  pulse when downstream src_vld && src_rdy
- flush  in  1  stop accepting requests and drain outstanding reads
- flush_done  out  1  one-cycle pulse when the drain completes
- busy  out  1  hold register valid or outstanding != 0
- spurious_err  out  1  sticky: response arrived with outstanding == 0
- timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset (asynchronous, active-high) clears all outputs, counters and state to 0.
- State after reset: IDLE; credit counter = CREDITS.
- States:
  - IDLE: no request held.
  - ISSUE: hold register valid; mem_req_vld = 1; address/data/we stable until fire.
  - DRAIN: flush in progress.
- Request acceptance:
  - req_rdy is combinational: state==IDLE && !flush && (req_we || (outstanding < MAX_OUTSTANDING && credits > 0)).
  - A fire (req_vld && req_rdy) captures the request into the hold register and moves IDLE->ISSUE the next cycle.
  - Only one request is held at a time; new acceptance resumes after the hold register empties.
- Issue:
  - A fire on mem_req_vld && mem_req_rdy returns to IDLE, or to DRAIN if flush was seen.
  - A read fire increments outstanding and decrements credits.
  - Writes are fire-and-forget: no counter change.
  - Credits are reserved at acceptance-check time and consumed at issue. The hold register blocks a second acceptance, so no over-commit is possible.
- Responses:
  - mem_rsp_vld with outstanding > 0 decrements outstanding.
  - m_rsp_vld and m_rsp_data are registered copies of mem_rsp_vld/mem_rsp_data, 1-cycle latency.
  - m_rsp_vld is a single-cycle pulse per response.
  - A response with outstanding == 0 is dropped (no m_rsp_vld) and sets spurious_err.
- Credits:
  - rsp_consumed increments credits.
  - A read issue and rsp_consumed in the same cycle leave credits unchanged.
  - rsp_consumed with credits == CREDITS is illegal: simulation assertion fires and the counter saturates.
- Simultaneous read issue and response: outstanding is unchanged.
- Flush:
  - While flush is high, req_rdy = 0.
  - From IDLE, flush goes to DRAIN. From ISSUE, the held request completes first.
  - DRAIN -> IDLE when outstanding == 0, pulsing flush_done for 1 cycle. Entering DRAIN with outstanding == 0 pulses flush_done the next cycle.
  - flush deasserting during DRAIN does not abort the drain.
- Counter widths: outstanding and credits are $clog2(max+1) bits, unsigned, saturating.
- Reset mid-operation discards the held request and all in-flight accounting. Late responses after reset set spurious_err.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With MEM_TIMEOUT_EN:
  - A watchdog counts cycles while outstanding > 0 and no mem_rsp_vld arrives; it resets on any response.
  - On reaching TIMEOUT_CYCLES: set timeout_err, force outstanding to 0, restore credits to CREDITS, exit DRAIN with flush_done if draining.
- Without MEM_TIMEOUT_EN: the counter is absent and timeout_err is tied 0.

Decomposition:
- constants_pkg (shared):
  - DATA_WIDTH and ADDR_WIDTH.
  - typedef mem_ctrl_state_t {IDLE, ISSUE, DRAIN}.
  - A packed mem_req_t {we, addr, wdata} for the hold register.
- One sub-module: sat_updown_ctr (parameterised saturating up/down counter), used for both outstanding and credits.

Test Plan:
- Single load at 0x10: mem_req_rdy high, memory returns 0xDEADBEEF 3 cycles later -> m_rsp_vld pulses 1 cycle after mem_rsp_vld with 0xDEADBEEF; outstanding back to 0.
- Three back-to-back loads, rsp_consumed held 0, CREDITS=2 -> the third load is refused (req_rdy=0) until one rsp_consumed pulse; no m_rsp_vld is ever lost.
- Store to 0x20 with mem_req_rdy low 4 cycles -> mem_req_vld/addr/wdata stable for 4 cycles, fire on cycle 5; credits and outstanding unchanged.
- Two loads outstanding, assert flush -> req_rdy=0, state DRAIN, flush_done pulses exactly 1 cycle after the second response.
- mem_rsp_vld with nothing outstanding -> no m_rsp_vld, spurious_err=1 until rst; rst asserted mid-ISSUE clears mem_req_vld asynchronously.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, load issued with no response -> timeout_err=1 at cycle 8 after issue; outstanding=0, credits=2.
